// File: rtl/det_sec_trama.sv
// Frame synchroniser: hunts for a sync word, confirms it over LOCK_CNT frames,
// flywheels through up to MISS_CNT-1 bad sync words and delivers each payload in parallel.
module det_sec_trama #(
   parameter int                SYNC_W       = 5,
   parameter logic [SYNC_W-1:0] SECUENCIA    = 5'b10100,
   parameter logic [SYNC_W-1:0] SEC_REINICIO = 5'b00000,
   parameter int                PAYLOAD_W    = 8,
   parameter int                LOCK_CNT     = 2,
   parameter int                MISS_CNT     = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bit_en,
   input  logic                 s_in,
   output logic                 valido,
   output logic                 nuevo_numero,
   output logic [PAYLOAD_W-1:0] dato,
   output logic [7:0]           err_cnt
);

   localparam int FRAME_LEN = SYNC_W + PAYLOAD_W;
   localparam int POS_W     = $clog2(FRAME_LEN);
   localparam int HIT_W     = $clog2(LOCK_CNT + 1);
   localparam int MISS_W    = $clog2(MISS_CNT + 1);

   typedef enum logic [3:0] {
      BUSQUEDA     = 4'b0001,
      VERIFICACION = 4'b0010,
      SINCRONIZADO = 4'b0100,
      FALLA        = 4'b1000
   } estado_t;

   // Current FSM state; kept as a named signal so checkers can bind to it.
   estado_t              estado;
   logic [SYNC_W-2:0]    sr;
   logic [POS_W-1:0]     pos;
   logic [PAYLOAD_W-1:0] pay;
   logic [HIT_W-1:0]     hits;
   logic [MISS_W-1:0]    misses;

   logic [SYNC_W-1:0]    w;
   logic [PAYLOAD_W-1:0] pay_nxt;
   logic [7:0]           err_inc;
   logic                 es_borde, es_fin_pay, en_pay, hit, reinicio, legal;

   always_comb begin
      w          = {sr, s_in};
      pay_nxt    = (pay << 1) | PAYLOAD_W'(s_in);
      es_borde   = (pos == POS_W'(FRAME_LEN - 1));
      es_fin_pay = (pos == POS_W'(PAYLOAD_W - 1));
      en_pay     = (pos < POS_W'(PAYLOAD_W));
      hit        = (w == SECUENCIA);
      reinicio   = (w == SEC_REINICIO);
      err_inc    = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
      legal      = (estado == BUSQUEDA) || (estado == VERIFICACION) ||
                   (estado == SINCRONIZADO) || (estado == FALLA);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado       <= BUSQUEDA;
         sr           <= '0;
         pos          <= '0;
         pay          <= '0;
         hits         <= '0;
         misses       <= '0;
         valido       <= 1'b0;
         nuevo_numero <= 1'b0;
         dato         <= '0;
         err_cnt      <= '0;
      end else begin
         nuevo_numero <= 1'b0;
         if (!legal) begin
            estado <= BUSQUEDA;
            valido <= 1'b0;
            hits   <= '0;
            misses <= '0;
         end else if (bit_en) begin
            sr  <= w[SYNC_W-2:0];
            pos <= es_borde ? '0 : pos + 1'b1;
            if (en_pay) pay <= pay_nxt;
            if (es_fin_pay && (estado == SINCRONIZADO || estado == FALLA)) begin
               dato         <= pay_nxt;
               nuevo_numero <= 1'b1;
            end
            case (estado)
               BUSQUEDA: begin
                  if (hit) begin
                     pos  <= '0;
                     hits <= HIT_W'(1);
                     if (LOCK_CNT == 1) begin
                        estado <= SINCRONIZADO;
                        valido <= 1'b1;
                     end else begin
                        estado <= VERIFICACION;
                     end
                  end
               end
               VERIFICACION: begin
                  if (es_borde) begin
                     if (hit) begin
                        hits <= hits + 1'b1;
                        if (hits == HIT_W'(LOCK_CNT - 1)) begin
                           estado <= SINCRONIZADO;
                           valido <= 1'b1;
                        end
                     end else begin
                        estado <= BUSQUEDA;
                        hits   <= '0;
                        misses <= '0;
                     end
                  end
               end
               SINCRONIZADO: begin
                  // The forced-unlock word wins over the miss bookkeeping.
                  if (es_borde) begin
                     if (reinicio) begin
                        estado <= BUSQUEDA;
                        valido <= 1'b0;
                        hits   <= '0;
                        misses <= '0;
                     end else if (!hit) begin
                        err_cnt <= err_inc;
                        if (MISS_CNT == 1) begin
                           estado <= BUSQUEDA;
                           valido <= 1'b0;
                           hits   <= '0;
                           misses <= '0;
                        end else begin
                           estado <= FALLA;
                           misses <= MISS_W'(1);
                        end
                     end
                  end
               end
               FALLA: begin
                  if (es_borde) begin
                     if (reinicio) begin
                        estado <= BUSQUEDA;
                        valido <= 1'b0;
                        hits   <= '0;
                        misses <= '0;
                     end else if (hit) begin
                        estado <= SINCRONIZADO;
                        misses <= '0;
                     end else begin
                        err_cnt <= err_inc;
                        if (misses == MISS_W'(MISS_CNT - 1)) begin
                           estado <= BUSQUEDA;
                           valido <= 1'b0;
                           hits   <= '0;
                           misses <= '0;
                        end else begin
                           misses <= misses + 1'b1;
                        end
                     end
                  end
               end
               default: estado <= BUSQUEDA;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_det_sec_trama.sv
// Directed bench for det_sec_trama: frames are shifted in bit by bit and every
// output is compared after each accepted bit against hand-derived values.
module tb_det_sec_trama;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_en = 1'b0;
   logic       s_in = 1'b0;
   logic       valido, nuevo_numero;
   logic [7:0] dato, err_cnt;

   int         total = 0;
   int         bad = 0;
   logic       exp_val = 1'b0;
   logic [7:0] exp_err = 8'd0;
   logic [7:0] exp_dato = 8'd0;

   det_sec_trama dut (
      .clk          (clk),
      .rst          (rst),
      .bit_en       (bit_en),
      .s_in         (s_in),
      .valido       (valido),
      .nuevo_numero (nuevo_numero),
      .dato         (dato),
      .err_cnt      (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Asserts reset between edges, checks outputs before the next edge, releases after it.
   task automatic do_reset();
      bit_en = 1'b0;
      #3 rst = 1'b0;
      #1;
      exp_val  = 1'b0;
      exp_err  = 8'd0;
      exp_dato = 8'd0;
      chk("rst_valido", 8'(valido), 8'd0);
      chk("rst_nuevo", 8'(nuevo_numero), 8'd0);
      chk("rst_dato", dato, 8'd0);
      chk("rst_err", err_cnt, 8'd0);
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // One frame: sync bits then payload, MSB first. Bit index 4 is the sync window end,
   // where valido/err_cnt take their new values; index 12 is the last payload bit.
   task automatic send_frame(input logic [4:0] sync, input logic [7:0] pay,
                             input logic v_after, input logic [7:0] e_after,
                             input logic pulse, input int gap, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         bit_en = 1'b1;
         if (i < 5) s_in = sync[4-i];
         else       s_in = pay[12-i];
         @(posedge clk);
         #1 bit_en = 1'b0;
         if (i == 4) begin
            exp_val = v_after;
            exp_err = e_after;
         end
         if (i == 12 && pulse) exp_dato = pay;
         chk($sformatf("valido@%0d", i), 8'(valido), 8'(exp_val));
         chk($sformatf("err_cnt@%0d", i), err_cnt, exp_err);
         chk($sformatf("dato@%0d", i), dato, exp_dato);
         chk($sformatf("nuevo@%0d", i), 8'(nuevo_numero), 8'(i == 12 && pulse));
         for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            chk("nuevo_gap", 8'(nuevo_numero), 8'd0);
            chk("valido_gap", 8'(valido), 8'(exp_val));
         end
      end
   endtask

   initial begin
      do_reset();

      // Lock on the 2nd sync word; first payload delivered from frame 2.
      send_frame(5'b10100, 8'hA5, 1'b0, 8'd0, 1'b0, 0, 13);
      send_frame(5'b10100, 8'hA5, 1'b1, 8'd0, 1'b1, 0, 13);
      send_frame(5'b10100, 8'hA5, 1'b1, 8'd0, 1'b1, 0, 13);

      // Two bad sync words are flywheeled; payloads keep flowing.
      send_frame(5'b10110, 8'h5A, 1'b1, 8'd1, 1'b1, 0, 13);
      send_frame(5'b10110, 8'hC3, 1'b1, 8'd2, 1'b1, 0, 13);
      send_frame(5'b10100, 8'h0F, 1'b1, 8'd2, 1'b1, 0, 13);
      send_frame(5'b10100, 8'h96, 1'b1, 8'd2, 1'b1, 0, 13);

      // Three bad sync words drop lock; 0x3C holds no sync pattern, so the hunt
      // realigns on the next true sync word and locks one frame later.
      do_reset();
      send_frame(5'b10100, 8'h3C, 1'b0, 8'd0, 1'b0, 0, 13);
      send_frame(5'b10100, 8'h3C, 1'b1, 8'd0, 1'b1, 0, 13);
      send_frame(5'b10110, 8'h81, 1'b1, 8'd1, 1'b1, 0, 13);
      send_frame(5'b10110, 8'h7E, 1'b1, 8'd2, 1'b1, 0, 13);
      send_frame(5'b10110, 8'h3C, 1'b0, 8'd3, 1'b0, 0, 13);
      send_frame(5'b10100, 8'h3C, 1'b0, 8'd3, 1'b0, 0, 13);
      send_frame(5'b10100, 8'h3C, 1'b1, 8'd3, 1'b1, 0, 13);

      // Forced-unlock word at a boundary: lock drops, err_cnt untouched.
      send_frame(5'b00000, 8'h3C, 1'b0, 8'd3, 1'b0, 0, 13);
      send_frame(5'b10100, 8'h3C, 1'b0, 8'd3, 1'b0, 0, 13);

      // Sparse bit_en: one valid bit every third cycle.
      do_reset();
      send_frame(5'b10100, 8'hA5, 1'b0, 8'd0, 1'b0, 2, 13);
      send_frame(5'b10100, 8'hA5, 1'b1, 8'd0, 1'b1, 2, 13);
      send_frame(5'b10100, 8'hA5, 1'b1, 8'd0, 1'b1, 2, 13);

      // Reset mid-payload, then re-lock with the same timing as after power-up.
      do_reset();
      send_frame(5'b10100, 8'hA5, 1'b0, 8'd0, 1'b0, 0, 13);
      send_frame(5'b10100, 8'hA5, 1'b1, 8'd0, 1'b1, 0, 13);
      send_frame(5'b10100, 8'hA5, 1'b1, 8'd0, 1'b0, 0, 9);
      do_reset();
      send_frame(5'b10100, 8'hA5, 1'b0, 8'd0, 1'b0, 0, 13);
      send_frame(5'b10100, 8'hA5, 1'b1, 8'd0, 1'b1, 0, 13);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/det_sec_trama.md
# det_sec_trama

Parametrised frame synchroniser for a serial bit stream. It hunts for a configurable sync word and confirms it over `LOCK_CNT` consecutive frame boundaries before declaring lock. Once locked, it flywheels through up to `MISS_CNT - 1` consecutive corrupted sync words and delivers each frame's payload as a parallel word with a one-cycle strobe. It is the next-generation sequence detector: it sits between the serial receiver and the word-level consumers.

## Interface
- `SYNC_W`, 5: sync word width in bits, ≥2.
- `SECUENCIA`, 5'b10100: sync word, `SYNC_W` bits; must differ from `SEC_REINICIO`.
- `SEC_REINICIO`, 5'b00000: forced-unlock word, `SYNC_W` bits.
- `PAYLOAD_W`, 8: payload bits per frame, ≥1. Frame length is `FRAME_LEN = SYNC_W + PAYLOAD_W`.
- `LOCK_CNT`, 2: consecutive sync hits needed to lock, ≥1.
- `MISS_CNT`, 3: consecutive sync misses that drop lock, ≥1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `bit_en`  in  1  `s_in` carries a valid bit this cycle.
- `s_in`  in  1  serial data, MSB first.
- `valido`  out  1  high while in SINCRONIZADO or FALLA.
- `nuevo_numero`  out  1  one-cycle pulse when `dato` has been updated.
- `dato`  out  `PAYLOAD_W`  last delivered payload word; first received bit is the MSB.
- `err_cnt`  out  8  saturating count of sync misses while locked.

## Operation
- All activity happens only on cycles where `bit_en` = 1. Cycles with `bit_en` = 0 change nothing, and `nuevo_numero` drops as usual.
- Window `w = {sr[SYNC_W-2:0], s_in}`. The shift register `sr` takes `w` on every bit.
- Position counter `pos` runs 0..`FRAME_LEN-1`.
  - The k-th bit after a sync window end sees `pos = k-1`.
  - Bits with `pos` 0..`PAYLOAD_W-1` are payload and shift into a payload register.
  - The bit with `pos = FRAME_LEN-1` is the boundary: `w` is checked there, and `pos` is set to 0 whatever the result.
- FSM is one-hot, 4 flops. Any illegal encoding goes to BUSQUEDA on the next edge.
  - BUSQUEDA: `w` is checked on every bit. If `w == SECUENCIA`: `pos`←0, `hits`←1, go to VERIFICACION (straight to SINCRONIZADO if `LOCK_CNT` = 1).
  - VERIFICACION, at the boundary:
    - Match: `hits`+1; when `hits` reaches `LOCK_CNT`, go to SINCRONIZADO.
    - Mismatch: go to BUSQUEDA. That bit is not re-checked as a hunt candidate.
  - SINCRONIZADO, at the boundary:
    - `w == SEC_REINICIO`: go to BUSQUEDA. This has priority over the miss logic.
    - Match: stay.
    - Otherwise: `misses`←1, `err_cnt`+1, go to FALLA (straight to BUSQUEDA if `MISS_CNT` = 1).
  - FALLA, at the boundary:
    - `SEC_REINICIO`: go to BUSQUEDA.
    - Match: `misses`←0, go to SINCRONIZADO.
    - Mismatch: `misses`+1, `err_cnt`+1; when `misses` reaches `MISS_CNT`, go to BUSQUEDA.
- Payload delivery happens only in SINCRONIZADO or FALLA. On the bit with `pos = PAYLOAD_W-1`, the completed word is loaded into `dato` and `nuevo_numero` is set for one cycle. Payloads seen in BUSQUEDA or VERIFICACION are discarded, and `dato` keeps its previous value.
- `err_cnt` saturates at 255 and is cleared only by reset.
- `hits` and `misses` are cleared on every entry to BUSQUEDA.

## Timing
- Reset (`rst` = 0) takes effect immediately, with no clock needed:
  - state = BUSQUEDA
  - `sr`, `pos`, `hits`, `misses` = 0
  - `valido` = 0, `nuevo_numero` = 0, `dato` = 0, `err_cnt` = 0
- Reset release is synchronised by the user; the first bit is accepted on the first edge with `rst` = 1.
- `valido` rises on the edge that consumes the `LOCK_CNT`-th matching boundary bit, so it is visible the cycle after. It falls on the edge that consumes the unlocking boundary bit.
- `dato` and `nuevo_numero` change on the edge that consumes the last payload bit. `nuevo_numero` is high for exactly one cycle, even when `bit_en` is held high.
- Reset mid-frame discards partial payload and lock state. No pulse is produced.

## Test plan
With defaults (`FRAME_LEN` = 13):
1. Reset, then continuous frames `10100` + `0xA5` with `bit_en` = 1 → `valido` = 1 the cycle after the 2nd sync word. The first `nuevo_numero` comes with `dato` = `0xA5` from frame 2's payload, then one pulse every 13 cycles.
2. Locked; corrupt 2 consecutive sync words (`10110`), then good ones → `valido` stays 1, `err_cnt` = 2, payload pulses continue.
3. Locked; corrupt 3 consecutive sync words → `valido` = 0 the cycle after the 3rd bad window, `err_cnt` = 3, no further `nuevo_numero` until re-lock after 2 good sync words.
4. Locked; send `00000` at a boundary → `valido` = 0 the next cycle, `err_cnt` unchanged.
5. Test 1 with `bit_en` high every 3rd cycle → same `dato` sequence; `nuevo_numero` stays 1 cycle wide; `valido` rises at bit count 18.
6. Assert `rst` = 0 mid-payload, between clock edges → all outputs 0 before the next edge; re-lock after release follows test 1 timing.
